// File: rtl/dbn_layer_sequencer.sv
// dbn_layer_sequencer: fetches data/weight chunks, closes the matrix_multi accumulation loop and captures sigmoid results per batch
//   clk, rst_n (async active-low), start                         : control
//   data_addr/data_rdata, weight_bank/weight_addr/weight_rdata   : memory reads, 1-cycle latency
//   data_buffer, weight_buffer_flat, sum_input                   : operands to matrix_multi
//   sum_output, sigmoid_output                                   : combinational results back from matrix_multi/sigmoid_16
//   result, result_valid, result_batch                           : per-batch activation to the result store
//   busy, done                                                   : run status
module dbn_layer_sequencer #(
  parameter int INPUT_SIZE  = 256,
  parameter int SUM_SIZE    = 512,
  parameter int LANES       = 16,
  parameter int NUM_CHUNKS  = 49,
  parameter int NUM_BATCHES = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [5:0]                  data_addr,
  input  logic [INPUT_SIZE-1:0]       data_rdata,
  output logic [2:0]                  weight_bank,
  output logic [9:0]                  weight_addr,
  input  logic [INPUT_SIZE-1:0]       weight_rdata,
  output logic [INPUT_SIZE-1:0]       data_buffer,
  output logic [LANES*INPUT_SIZE-1:0] weight_buffer_flat,
  output logic [SUM_SIZE-1:0]         sum_input,
  input  logic [SUM_SIZE-1:0]         sum_output,
  input  logic [INPUT_SIZE-1:0]       sigmoid_output,
  output logic [INPUT_SIZE-1:0]       result,
  output logic                        result_valid,
  output logic [2:0]                  result_batch,
  output logic                        busy,
  output logic                        done
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPT, ACC, STORE} state_t;
  localparam logic [5:0] LAST_CHUNK = 6'(NUM_CHUNKS - 1);
  localparam logic [2:0] LAST_BATCH = 3'(NUM_BATCHES - 1);
  state_t                             state_q;
  logic [5:0]                         chunk_q;
  logic [3:0]                         k_q;
  logic [2:0]                         batch_q;
  logic [LANES-1:0][INPUT_SIZE-1:0]   wbuf_q;
  logic [INPUT_SIZE-1:0]              dbuf_q;
  logic [SUM_SIZE-1:0]                sum_q;
  logic [INPUT_SIZE-1:0]              result_q;
  logic [2:0]                         result_batch_q;
  logic                               result_valid_q;
  logic                               done_q;
  // chunk*16 + k with k < 16 is a plain concatenation
  assign data_addr          = chunk_q;
  assign weight_addr        = {chunk_q, k_q};
  assign weight_bank        = batch_q;
  assign data_buffer        = dbuf_q;
  assign weight_buffer_flat = wbuf_q;
  assign sum_input          = sum_q;
  assign result             = result_q;
  assign result_valid       = result_valid_q;
  assign result_batch       = result_batch_q;
  assign busy               = state_q != IDLE;
  assign done               = done_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      chunk_q        <= '0;
      k_q            <= '0;
      batch_q        <= '0;
      wbuf_q         <= '0;
      dbuf_q         <= '0;
      sum_q          <= '0;
      result_q       <= '0;
      result_batch_q <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= FETCH;
          chunk_q <= '0;
          k_q     <= '0;
          batch_q <= '0;
          sum_q   <= '0;
        end
        FETCH: begin
          // read data lags the address by one cycle, so word k-1 lands while k is issued
          if (k_q != 4'd0) wbuf_q[k_q - 4'd1] <= weight_rdata;
          if (k_q == 4'd1) dbuf_q <= data_rdata;
          k_q <= k_q + 4'd1;
          if (k_q == 4'd15) state_q <= CAPT;
        end
        CAPT: begin
          wbuf_q[LANES-1] <= weight_rdata;
          state_q         <= ACC;
        end
        ACC: begin
          sum_q   <= sum_output;
          k_q     <= '0;
          chunk_q <= (chunk_q == LAST_CHUNK) ? chunk_q : chunk_q + 6'd1;
          state_q <= (chunk_q == LAST_CHUNK) ? STORE : FETCH;
        end
        STORE: begin
          result_q       <= sigmoid_output;
          result_batch_q <= batch_q;
          result_valid_q <= 1'b1;
          sum_q          <= '0;
          chunk_q        <= '0;
          done_q         <= batch_q == LAST_BATCH;
          batch_q        <= (batch_q == LAST_BATCH) ? batch_q : batch_q + 3'd1;
          state_q        <= (batch_q == LAST_BATCH) ? IDLE : FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbn_layer_sequencer.sv
// tb_dbn_layer_sequencer: directed checks of addressing, accumulation, batching, start handling and async reset
module tb_dbn_layer_sequencer;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    data_addr;
  logic [255:0]  data_rdata = '0;
  logic [2:0]    weight_bank;
  logic [9:0]    weight_addr;
  logic [255:0]  weight_rdata = '0;
  logic [255:0]  data_buffer;
  logic [4095:0] weight_buffer_flat;
  logic [511:0]  sum_input;
  logic [511:0]  sum_output;
  logic [255:0]  sigmoid_output;
  logic [255:0]  result;
  logic          result_valid;
  logic [2:0]    result_batch;
  logic          busy;
  logic          done;
  int            checks = 0;
  int            failures = 0;
  int            e = 0;

  dbn_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .data_addr(data_addr), .data_rdata(data_rdata),
    .weight_bank(weight_bank), .weight_addr(weight_addr), .weight_rdata(weight_rdata),
    .data_buffer(data_buffer), .weight_buffer_flat(weight_buffer_flat),
    .sum_input(sum_input), .sum_output(sum_output), .sigmoid_output(sigmoid_output),
    .result(result), .result_valid(result_valid), .result_batch(result_batch),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // memories return their own address one cycle later; MAC stub adds one per step
  always @(posedge clk) begin
    data_rdata   <= 256'(data_addr);
    weight_rdata <= 256'(weight_addr);
  end
  assign sum_output     = sum_input + 512'd1;
  assign sigmoid_output = sum_output[255:0];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after edge t of the current run (edge 0 samples start)
  task automatic adv(input int t);
    repeat (t - e) @(posedge clk);
    #1;
    e = t;
  endtask

  function automatic logic [255:0] wword(input int k);
    return weight_buffer_flat[k*256 +: 256];
  endfunction

  initial begin
    #1;
    chk("rst_busy", 256'(busy), 0);
    chk("rst_done", 256'(done), 0);
    chk("rst_valid", 256'(result_valid), 0);
    chk("rst_waddr", 256'(weight_addr), 0);
    chk("rst_sum", 256'(sum_input), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // run 1
    start = 1'b1; e = -1; adv(0); start = 1'b0;
    chk("r1_busy", 256'(busy), 1);
    adv(1);
    chk("r1_waddr_k1", 256'(weight_addr), 1);
    adv(17);
    chk("acc0_dbuf", data_buffer, 0);
    chk("acc0_w3", wword(3), 3);
    chk("acc0_w15", wword(15), 15);
    chk("acc0_sum", 256'(sum_input), 0);
    adv(18);
    chk("c1_sum", 256'(sum_input), 1);
    chk("c1_daddr", 256'(data_addr), 1);
    chk("c1_waddr", 256'(weight_addr), 16);
    adv(881);
    chk("acc48_dbuf", data_buffer, 48);
    chk("acc48_w0", wword(0), 768);
    chk("acc48_w15", wword(15), 783);
    chk("acc48_daddr", 256'(data_addr), 48);
    adv(882);
    chk("store_valid", 256'(result_valid), 0);
    chk("store_sum", 256'(sum_input), 49);
    adv(883);
    chk("b0_valid", 256'(result_valid), 1);
    // sigmoid sees sum_output, one stub step beyond the 49 accumulated chunks
    chk("b0_result", result, 50);
    chk("b0_rbatch", 256'(result_batch), 0);
    chk("b0_sum_clr", 256'(sum_input), 0);
    chk("b0_bank", 256'(weight_bank), 1);
    chk("b0_done", 256'(done), 0);
    chk("b0_busy", 256'(busy), 1);
    adv(884);
    chk("b0_pulse", 256'(result_valid), 0);
    adv(883 + 17);
    chk("b1_w5", wword(5), 5);
    chk("b1_acc0_sum", 256'(sum_input), 0);
    for (int n = 1; n < 7; n++) begin
      adv(883 * (n + 1) - 1);
      chk("bn_pre_valid", 256'(result_valid), 0);
      adv(883 * (n + 1));
      chk("bn_valid", 256'(result_valid), 1);
      chk("bn_result", result, 50);
      chk("bn_rbatch", 256'(result_batch), 256'(n));
      chk("bn_done", 256'(done), n == 6 ? 1 : 0);
      chk("bn_busy", 256'(busy), n == 6 ? 0 : 1);
      chk("bn_bank", 256'(weight_bank), n == 6 ? 6 : 256'(n + 1));
    end
    adv(6182);
    chk("end_done", 256'(done), 0);
    chk("end_valid", 256'(result_valid), 0);
    chk("end_busy", 256'(busy), 0);
    // run 2 with start held high throughout
    start = 1'b1; e = -1; adv(0);
    adv(500);
    chk("held_daddr", 256'(data_addr), 27);
    chk("held_waddr", 256'(weight_addr), 446);
    adv(6181);
    chk("held_done", 256'(done), 1);
    adv(6182);
    chk("restart_busy", 256'(busy), 1);
    chk("restart_waddr0", 256'(weight_addr), 0);
    adv(6183);
    chk("restart_waddr1", 256'(weight_addr), 1);
    start = 1'b0;
    e = 1;
    adv(1000);
    chk("pre_rst_bank", 256'(weight_bank), 1);
    chk("pre_rst_sum", 256'(sum_input), 6);
    // asynchronous reset in the middle of a fetch
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 256'(busy), 0);
    chk("arst_daddr", 256'(data_addr), 0);
    chk("arst_waddr", 256'(weight_addr), 0);
    chk("arst_bank", 256'(weight_bank), 0);
    chk("arst_sum", 256'(sum_input), 0);
    chk("arst_result", result, 0);
    chk("arst_dbuf", data_buffer, 0);
    chk("arst_wbuf", 256'(|weight_buffer_flat), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_valid", 256'(result_valid), 0);
    chk("arst_hold_done", 256'(done), 0);
    rst_n = 1'b1;
    start = 1'b1; e = -1; adv(0); start = 1'b0;
    adv(883);
    chk("post_rst_valid", 256'(result_valid), 1);
    chk("post_rst_result", result, 50);
    chk("post_rst_rbatch", 256'(result_batch), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
